// File: rtl/reaction_timer.sv
// Per-target reaction timer: ms stopwatch with hit/miss statistics and a bit-serial average divider.
// States: IDLE (stats held, waiting for a session) | MEASURE (timing a target) | DIVIDE (timing + averaging)
module reaction_timer #(
  parameter int unsigned TICK_DIV   = 100000,
  parameter int unsigned TIMEOUT_MS = 2000,
  parameter int unsigned MAX_MS     = 9999
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        jump_start,
  input  logic        new_ball,
  output logic [13:0] last_ms,
  output logic [13:0] best_ms,
  output logic [13:0] avg_ms,
  output logic        avg_busy,
  output logic [7:0]  hit_count,
  output logic [7:0]  miss_count,
  output logic        timeout_pulse
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [13:0]   MS_MAX    = 14'(MAX_MS);
  localparam logic [13:0]   MS_TO     = 14'(TIMEOUT_MS);
  localparam logic [21:0]   Q_MAX     = 22'(MAX_MS);
  localparam logic [4:0]    DIV_ITER  = 5'd22;

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_DIVIDE} state_t;

  state_t        state_q, state_d;
  logic [TW-1:0] tick_q, tick_d;
  logic [13:0]   ms_q, ms_d, last_q, last_d, best_q, best_d, avg_q, avg_d;
  logic [7:0]    hit_q, hit_d, miss_q, miss_d;
  logic [21:0]   sum_q, sum_d, dvd_q, dvd_d;
  logic [7:0]    rem_q, rem_d, dsr_q, dsr_d;
  logic [4:0]    div_cnt_q, div_cnt_d;
  logic          pulse_q, pulse_d, redo_q, redo_d;

  logic        running, hit, timeout, qbit;
  logic [8:0]  trial;
  logic [7:0]  diff;
  logic [21:0] quo;
  logic [22:0] sum_ext;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      ms_q      <= '0;
      last_q    <= '0;
      best_q    <= MS_MAX;
      avg_q     <= '0;
      hit_q     <= '0;
      miss_q    <= '0;
      sum_q     <= '0;
      dvd_q     <= '0;
      rem_q     <= '0;
      dsr_q     <= '0;
      div_cnt_q <= '0;
      pulse_q   <= 1'b0;
      redo_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      ms_q      <= ms_d;
      last_q    <= last_d;
      best_q    <= best_d;
      avg_q     <= avg_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      sum_q     <= sum_d;
      dvd_q     <= dvd_d;
      rem_q     <= rem_d;
      dsr_q     <= dsr_d;
      div_cnt_q <= div_cnt_d;
      pulse_q   <= pulse_d;
      redo_q    <= redo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    ms_d      = ms_q;
    last_d    = last_q;
    best_d    = best_q;
    avg_d     = avg_q;
    hit_d     = hit_q;
    miss_d    = miss_q;
    sum_d     = sum_q;
    dvd_d     = dvd_q;
    rem_d     = rem_q;
    dsr_d     = dsr_q;
    div_cnt_d = div_cnt_q;
    pulse_d   = 1'b0;
    redo_d    = redo_q;

    running = (state_q != S_IDLE);
    hit     = running && new_ball;
    timeout = running && (ms_q == MS_TO) && !new_ball;
    // One restoring-divide step: shift the next dividend bit into the remainder.
    trial   = {rem_q, dvd_q[21]};
    qbit    = (trial >= {1'b0, dsr_q});
    diff    = trial[7:0] - dsr_q;
    quo     = {dvd_q[20:0], qbit};
    sum_ext = {1'b0, sum_q} + {9'd0, ms_q};

    if (running) begin
      if (tick_q == TICK_LAST) begin
        tick_d = '0;
        if (ms_q < MS_MAX) ms_d = ms_q + 14'd1;
      end else begin
        tick_d = tick_q + TW'(1);
      end
    end

    if (!start) begin
      state_d   = S_IDLE;
      redo_d    = 1'b0;
      div_cnt_d = '0;
    end else if (jump_start) begin
      state_d   = S_MEASURE;
      tick_d    = '0;
      ms_d      = '0;
      last_d    = '0;
      best_d    = MS_MAX;
      avg_d     = '0;
      hit_d     = '0;
      miss_d    = '0;
      sum_d     = '0;
      redo_d    = 1'b0;
      div_cnt_d = '0;
    end else if (running) begin
      if (hit) begin
        last_d = ms_q;
        best_d = (ms_q < best_q) ? ms_q : best_q;
        sum_d  = sum_ext[22] ? 22'h3F_FFFF : sum_ext[21:0];
        if (hit_q != 8'hFF) hit_d = hit_q + 8'd1;
        tick_d = '0;
        ms_d   = '0;
      end else if (timeout) begin
        pulse_d = 1'b1;
        if (miss_q != 8'hFF) miss_d = miss_q + 8'd1;
        tick_d = '0;
        ms_d   = '0;
      end

      if (state_q == S_MEASURE) begin
        if (hit) begin
          state_d   = S_DIVIDE;
          div_cnt_d = '0;
          redo_d    = 1'b0;
        end
      end else begin
        if (hit) redo_d = 1'b1;
        if (div_cnt_q == 5'd0) begin
          dvd_d     = sum_q;
          rem_d     = '0;
          dsr_d     = hit_q;
          div_cnt_d = DIV_ITER;
        end else begin
          dvd_d     = quo;
          rem_d     = qbit ? diff : trial[7:0];
          div_cnt_d = div_cnt_q - 5'd1;
          if (div_cnt_q == 5'd1) begin
            avg_d = (quo > Q_MAX) ? MS_MAX : quo[13:0];
            // A hit that arrived mid-divide forces a fresh pass over the updated sum.
            if (redo_q || hit) begin
              redo_d    = 1'b0;
              div_cnt_d = '0;
            end else begin
              state_d = S_MEASURE;
            end
          end
        end
      end
    end
  end

  always_comb begin
    last_ms       = last_q;
    best_ms       = best_q;
    avg_ms        = avg_q;
    avg_busy      = (state_q == S_DIVIDE);
    hit_count     = hit_q;
    miss_count    = miss_q;
    timeout_pulse = pulse_q;
  end

endmodule

// File: tb/tb_reaction_timer.sv
// Directed bench for reaction_timer with TICK_DIV=4, TIMEOUT_MS=20, MAX_MS=50.
module tb_reaction_timer;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        jump_start = 1'b0;
  logic        new_ball = 1'b0;
  logic [13:0] last_ms, best_ms, avg_ms;
  logic        avg_busy, timeout_pulse;
  logic [7:0]  hit_count, miss_count;
  logic [59:0] snap;

  int checks = 0;
  int failures = 0;
  int since_clr = 0;

  localparam logic [59:0] RESET_SNAP = {14'd0, 14'd50, 14'd0, 1'b0, 8'd0, 8'd0, 1'b0};

  always #5 clk = ~clk;

  reaction_timer #(.TICK_DIV(4), .TIMEOUT_MS(20), .MAX_MS(50)) dut (
    .clk(clk), .rst(rst), .start(start), .jump_start(jump_start), .new_ball(new_ball),
    .last_ms(last_ms), .best_ms(best_ms), .avg_ms(avg_ms), .avg_busy(avg_busy),
    .hit_count(hit_count), .miss_count(miss_count), .timeout_pulse(timeout_pulse)
  );

  assign snap = {last_ms, best_ms, avg_ms, avg_busy, hit_count, miss_count, timeout_pulse};

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      since_clr++;
    end
  endtask

  // Present new_ball so it is sampled on the edge where the ms counter reads ms.
  task automatic hit_at(input int ms);
    step(4 * ms - since_clr);
    new_ball = 1'b1;
    step(1);
    new_ball = 1'b0;
    since_clr = 0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    step(2);
    checks++;
    if (snap !== RESET_SNAP) begin
      failures++;
      $display("FAIL reset_values: got %h expected %h", snap, RESET_SNAP);
    end
    rst = 1'b1;
    new_ball = 1'b1;
    step(1);
    new_ball = 1'b0;
    step(1);
    checks++;
    if (snap !== RESET_SNAP) begin
      failures++;
      $display("FAIL idle_ignores_hit: got %h expected %h", snap, RESET_SNAP);
    end
  endtask

  task automatic test_first_hit;
    start = 1'b1;
    jump_start = 1'b1;
    step(1);
    jump_start = 1'b0;
    since_clr = 0;
    hit_at(10);
    checks++;
    if ({last_ms, best_ms, hit_count, avg_busy} !== {14'd10, 14'd10, 8'd1, 1'b1}) begin
      failures++;
      $display("FAIL first_hit: got last=%0d best=%0d hit=%0d busy=%0d expected 10 10 1 1",
               last_ms, best_ms, hit_count, avg_busy);
    end
    step(22);
    checks++;
    if ({avg_busy, avg_ms} !== {1'b1, 14'd0}) begin
      failures++;
      $display("FAIL avg_latency_early: got busy=%0d avg=%0d expected 1 0", avg_busy, avg_ms);
    end
    step(1);
    checks++;
    if ({avg_busy, avg_ms} !== {1'b0, 14'd10}) begin
      failures++;
      $display("FAIL avg_first: got busy=%0d avg=%0d expected 0 10", avg_busy, avg_ms);
    end
  endtask

  task automatic test_stats;
    hit_at(6);
    checks++;
    if ({last_ms, best_ms, hit_count} !== {14'd6, 14'd6, 8'd2}) begin
      failures++;
      $display("FAIL hit_6ms: got last=%0d best=%0d hit=%0d expected 6 6 2", last_ms, best_ms, hit_count);
    end
    step(23);
    checks++;
    if ({avg_busy, avg_ms} !== {1'b0, 14'd8}) begin
      failures++;
      $display("FAIL avg_two: got busy=%0d avg=%0d expected 0 8", avg_busy, avg_ms);
    end
    hit_at(7);
    checks++;
    if ({last_ms, best_ms, hit_count} !== {14'd7, 14'd6, 8'd3}) begin
      failures++;
      $display("FAIL hit_7ms: got last=%0d best=%0d hit=%0d expected 7 6 3", last_ms, best_ms, hit_count);
    end
    step(23);
    checks++;
    if (avg_ms !== 14'd7) begin
      failures++;
      $display("FAIL avg_three: got %0d expected 7", avg_ms);
    end
  endtask

  task automatic test_timeout;
    step(80 - since_clr);
    checks++;
    if ({timeout_pulse, miss_count} !== {1'b0, 8'd0}) begin
      failures++;
      $display("FAIL pre_timeout: got pulse=%0d miss=%0d expected 0 0", timeout_pulse, miss_count);
    end
    step(1);
    since_clr = 0;
    checks++;
    if ({timeout_pulse, miss_count, hit_count} !== {1'b1, 8'd1, 8'd3}) begin
      failures++;
      $display("FAIL timeout: got pulse=%0d miss=%0d hit=%0d expected 1 1 3",
               timeout_pulse, miss_count, hit_count);
    end
    step(1);
    checks++;
    if ({timeout_pulse, miss_count} !== {1'b0, 8'd1}) begin
      failures++;
      $display("FAIL pulse_width: got pulse=%0d miss=%0d expected 0 1", timeout_pulse, miss_count);
    end
    hit_at(20);
    checks++;
    if ({last_ms, hit_count, miss_count, timeout_pulse} !== {14'd20, 8'd4, 8'd1, 1'b0}) begin
      failures++;
      $display("FAIL hit_on_timeout: got last=%0d hit=%0d miss=%0d pulse=%0d expected 20 4 1 0",
               last_ms, hit_count, miss_count, timeout_pulse);
    end
    step(23);
    checks++;
    if ({avg_ms, miss_count} !== {14'd10, 8'd1}) begin
      failures++;
      $display("FAIL avg_four: got avg=%0d miss=%0d expected 10 1", avg_ms, miss_count);
    end
  endtask

  task automatic test_back_to_back;
    bit gap;
    gap = 1'b0;
    hit_at(10);
    step(5);
    new_ball = 1'b1;
    step(1);
    new_ball = 1'b0;
    since_clr = 0;
    checks++;
    if ({last_ms, best_ms, hit_count, avg_busy} !== {14'd1, 14'd1, 8'd6, 1'b1}) begin
      failures++;
      $display("FAIL hit_in_divide: got last=%0d best=%0d hit=%0d busy=%0d expected 1 1 6 1",
               last_ms, best_ms, hit_count, avg_busy);
    end
    for (int i = 0; i < 39; i++) begin
      step(1);
      if (avg_busy !== 1'b1) gap = 1'b1;
    end
    checks++;
    if (gap) begin
      failures++;
      $display("FAIL busy_continuous: got a low busy cycle expected busy held high");
    end
    step(1);
    checks++;
    if ({avg_busy, avg_ms} !== {1'b0, 14'd9}) begin
      failures++;
      $display("FAIL avg_redo: got busy=%0d avg=%0d expected 0 9", avg_busy, avg_ms);
    end
  endtask

  task automatic test_reset_mid_divide;
    hit_at(12);
    step(3);
    rst = 1'b0;
    step(1);
    rst = 1'b1;
    since_clr = 0;
    checks++;
    if (snap !== RESET_SNAP) begin
      failures++;
      $display("FAIL reset_in_divide: got %h expected %h", snap, RESET_SNAP);
    end
  endtask

  task automatic test_stop_and_jump;
    bit moved;
    logic [59:0] frozen;
    moved = 1'b0;
    frozen = {14'd5, 14'd5, 14'd5, 1'b0, 8'd1, 8'd0, 1'b0};
    jump_start = 1'b1;
    step(1);
    jump_start = 1'b0;
    since_clr = 0;
    hit_at(5);
    step(23);
    checks++;
    if (snap !== frozen) begin
      failures++;
      $display("FAIL pre_stop: got %h expected %h", snap, frozen);
    end
    start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      new_ball = (i == 50);
      step(1);
      if (snap !== frozen) moved = 1'b1;
    end
    new_ball = 1'b0;
    checks++;
    if (moved) begin
      failures++;
      $display("FAIL stop_freeze: got %h expected %h held", snap, frozen);
    end
    start = 1'b1;
    jump_start = 1'b1;
    step(1);
    jump_start = 1'b0;
    since_clr = 0;
    checks++;
    if (snap !== RESET_SNAP) begin
      failures++;
      $display("FAIL jump_clears: got %h expected %h", snap, RESET_SNAP);
    end
    hit_at(4);
    step(2);
    jump_start = 1'b1;
    step(1);
    jump_start = 1'b0;
    since_clr = 0;
    checks++;
    if (snap !== RESET_SNAP) begin
      failures++;
      $display("FAIL jump_aborts_divide: got %h expected %h", snap, RESET_SNAP);
    end
    hit_at(3);
    step(23);
    checks++;
    if ({last_ms, hit_count, avg_ms, avg_busy} !== {14'd3, 8'd1, 14'd3, 1'b0}) begin
      failures++;
      $display("FAIL after_abort: got last=%0d hit=%0d avg=%0d busy=%0d expected 3 1 3 0",
               last_ms, hit_count, avg_ms, avg_busy);
    end
  endtask

  initial begin
    test_reset();
    test_first_hit();
    test_stats();
    test_timeout();
    test_back_to_back();
    test_reset_mid_divide();
    test_stop_and_jump();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
